dual_edge_sched: RTL and testbench
==================================

# dual_edge_sched

Round-robin scheduler that shares one dual-edge capture datapath (posedge path P, negedge path N, output flop selected by `en`) among `NREQ` requesters. It arbitrates requests, drives the datapath's `d` and `en` inputs, waits for both edge paths to settle, and returns the selected result to the winning requester. It sits between the requesters and the datapath and is the only driver of the datapath's `d` and `en` inputs.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `SETTLE_CYC`, default 1: cycles that `dp_d` is held before select, range 1..15.
- `clk`  in  1: clock. All controller logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: per-requester request level.
- `req_sel`  in  NREQ: per-requester path choice; 1 = P path, 0 = N path.
- `req_data`  in  NREQ: per-requester 1-bit data for `dp_d`.
- `gnt`  out  NREQ: one-hot grant, one-cycle pulse.
- `dp_d`  out  1: to datapath `d`.
- `dp_en`  out  1: to datapath `en`.
- `dp_q`  in  1: from datapath `q`.
- `rsp_valid`  out  1: result valid, one-cycle pulse.
- `rsp_id`  out  $clog2(NREQ): index of the requester that owns the result.
- `rsp_data`  out  1: result bit.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states are IDLE, DRIVE, SELECT and RESP.
- IDLE: outputs `dp_d`, `dp_en` and `busy` are 0. If any `req` is high, the arbiter picks a winner `w`, the block latches `req_data[w]` and `req_sel[w]`, and the FSM goes to DRIVE.
- DRIVE: lasts `SETTLE_CYC` cycles.
  - `gnt[w]` is high in the first DRIVE cycle only.
  - `dp_d` equals the latched data.
  - `dp_en` is 0.
- SELECT: lasts one cycle. `dp_d` is held and `dp_en` equals the latched select.
- RESP: lasts one cycle.
  - `rsp_valid` = 1, `rsp_id` = `w`, `rsp_data` = `dp_q`.
  - If any `req` is high, a new winner is arbitrated and latched in this cycle and the FSM goes straight to DRIVE.
  - Otherwise the FSM goes to IDLE.
- Arbitration is round-robin. The search starts at `last_gnt+1` modulo `NREQ`. `last_gnt` updates on every grant. Its reset value is `NREQ-1`, so requester 0 wins first.
- Requesters hold `req`, `req_sel` and `req_data` stable until they see `gnt`. A grant consumes the request. If `req` is still high after `gnt`, that is a new request.
- Dropping `req` before the grant is legal. That requester is simply not considered.
- The request bit of the requester currently being served is masked from arbitration until RESP.
- Reset mid-operation returns the FSM to IDLE immediately. The in-flight result is discarded, and no `rsp_valid` or `gnt` is issued for it.

## Timing
- Reset values:
  - `gnt` = 0, `dp_d` = 0, `dp_en` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `busy` = 0, state = IDLE, `last_gnt` = `NREQ-1`.
- All outputs are registered. `rsp_data` is the `dp_q` value sampled at the rising edge that ends SELECT, so it reflects the selection made during SELECT.
- Let the request be sampled at rising edge k:
  - `gnt` is high during cycle k+1.
  - SELECT is cycle k+1+`SETTLE_CYC`.
  - `rsp_valid` is high during cycle k+2+`SETTLE_CYC`.
- Back-to-back throughput is one transaction per `SETTLE_CYC`+2 cycles.
- When `req` and RESP occur in the same cycle, that requester's `gnt` comes in the next cycle, with no IDLE bubble.
- `gnt` and `rsp_valid` may be high in the same cycle only for different transactions. This cannot happen while `SETTLE_CYC` ≥ 1, and the bench asserts that it never does.

## Configuration
- `DUAL_EDGE_SCHED_PERF_EN` defined:
  - Adds output `perf_cnt`, 16 bits, reset value 0.
  - The counter increments on every `rsp_valid` and wraps from 0xFFFF to 0x0000.
- Not defined: the `perf_cnt` port and the counter are absent. All other behaviour is identical.

## Structure
- Package `dual_edge_sched_pkg` holds:
  - the FSM state enum `sched_state_e` (IDLE, DRIVE, SELECT, RESP);
  - the path select constants `SEL_P` = 1 and `SEL_N` = 0.
- Sub-module `rr_arbiter`, parameterised by `NREQ`:
  - inputs: request vector, mask, `last_gnt`;
  - outputs: one-hot winner and winner index;
  - purely combinational; the pointer lives in the parent.

## Test plan
All scenarios use `NREQ` = 4 and `SETTLE_CYC` = 1.
- Reset then a single request: `req` = 0001, `req_sel[0]` = 1, `req_data[0]` = 1.
  - `gnt` = 0001 one cycle later.
  - `dp_en` = 1 in SELECT.
  - `rsp_valid` 3 cycles after sampling, with `rsp_id` = 0 and `rsp_data` equal to the golden-model P-path value.
- All four requesting continuously: grants go in order 0,1,2,3,0, spaced 3 cycles apart, with no IDLE between transactions.
- `req` = 0101 after requester 0 was served: requester 2 is granted next, then requester 0.
- N-path select: `req_sel[1]` = 0 with data toggled across 8 transactions. `rsp_data` matches the golden N-path value every time.
- `rst_n` pulsed low during SELECT: no `rsp_valid` for that transaction, all outputs go to 0, and the next grant goes to requester 0.
- With `DUAL_EDGE_SCHED_PERF_EN`: after 65537 transactions, `perf_cnt` = 1.

Source files
------------

// File: rtl/dual_edge_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_edge_sched_pkg
// Purpose  : Shared types and constants for the dual-edge capture scheduler.
//            Holds the controller FSM state encoding, the datapath path-select
//            constants and the settle-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dual_edge_sched_pkg;

  // Controller FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SELECT = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Datapath en values: 1 picks the posedge path, 0 the negedge path.
  localparam logic SEL_P = 1'b1;
  localparam logic SEL_N = 1'b0;

  // Settle counter width; covers SETTLE_CYC up to 15.
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dual_edge_sched_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches the eligible
//            requests (req & ~mask) starting one past last_gnt, wrapping
//            modulo NREQ. The priority pointer itself lives in the parent.
// Ports    : req      in  [NREQ-1:0]          request vector
//            mask     in  [NREQ-1:0]          requests excluded from the search
//            last_gnt in  [$clog2(NREQ)-1:0]  index granted most recently
//            win_oh   out [NREQ-1:0]          one-hot winner (0 if none)
//            win_idx  out [$clog2(NREQ)-1:0]  winner index (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         mask,
  input  logic [$clog2(NREQ)-1:0] last_gnt,
  output logic [NREQ-1:0]         win_oh,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] eligible;
  logic            found;
  int              cand;

  assign eligible = req & ~mask;

  // Walk NREQ positions beginning after the last winner; the first eligible
  // position wins. The modulo keeps the walk correct for non-power-of-two NREQ.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_gnt) + i) % NREQ;
      if (!found && eligible[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = IDW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_edge_sched.sv
`default_nettype none
// ============================================================================
// Module   : dual_edge_sched
// Purpose  : Round-robin scheduler sharing one dual-edge capture datapath
//            among NREQ requesters. A winner's data is driven on dp_d for
//            SETTLE_CYC cycles, then dp_en selects the P or N path for one
//            cycle, and dp_q is captured as the response.
// Config   : DUAL_EDGE_SCHED_PERF_EN - adds 16-bit perf_cnt output counting
//            responses (wraps at 0xFFFF).
// Ports    : clk        in   clock (rising edge)
//            rst_n      in   asynchronous active-low reset
//            req        in   [NREQ-1:0] request levels
//            req_sel    in   [NREQ-1:0] path choice (1 = P, 0 = N)
//            req_data   in   [NREQ-1:0] data bit per requester
//            gnt        out  [NREQ-1:0] one-hot grant pulse
//            dp_d       out  datapath d
//            dp_en      out  datapath en
//            dp_q       in   datapath q
//            rsp_valid  out  response pulse
//            rsp_id     out  [$clog2(NREQ)-1:0] owner of the response
//            rsp_data   out  response bit
//            busy       out  high whenever the FSM is not IDLE
//            perf_cnt   out  [15:0] response count (only with the macro)
// Revision : 1.0 - initial release
// ============================================================================
module dual_edge_sched
  import dual_edge_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_sel,
  input  logic [NREQ-1:0]         req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    dp_d,
  output logic                    dp_en,
  input  logic                    dp_q,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_data,
  output logic                    busy
`ifdef DUAL_EDGE_SCHED_PERF_EN
  ,
  output logic [15:0]             perf_cnt
`endif
);

  localparam int                IDW      = $clog2(NREQ);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDW-1:0]    PTR_INIT = IDW'(NREQ - 1);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   last_gnt_q, last_gnt_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic             cur_sel_q, cur_sel_d;
  logic             cur_data_q, cur_data_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             dp_d_q, dp_d_d;
  logic             dp_en_q, dp_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_data_q, rsp_data_d;
  logic             busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] serve_oh;
  logic [NREQ-1:0] arb_mask;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;
  logic            any_win;
  logic            grant_now;

  assign serve_oh = {{(NREQ-1){1'b0}}, 1'b1} << cur_id_q;
  // The requester in flight is hidden from the arbiter until its RESP cycle.
  assign arb_mask = ((state_q == DRIVE) || (state_q == SELECT)) ? serve_oh : '0;

  rr_arbiter #(
    .NREQ     (NREQ)
  ) u_arb (
    .req      (req),
    .mask     (arb_mask),
    .last_gnt (last_gnt_q),
    .win_oh   (win_oh),
    .win_idx  (win_idx)
  );

  assign any_win = |win_oh;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic. Every output is a flop, so the values
  // computed here appear one cycle later: the grant decision made in IDLE or
  // RESP shows up as gnt during the first DRIVE cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    cur_id_d    = cur_id_q;
    cur_sel_d   = cur_sel_q;
    cur_data_d  = cur_data_q;
    gnt_d       = '0;
    dp_d_d      = 1'b0;
    dp_en_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = 1'b0;
    grant_now   = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_now = any_win;
      end
      DRIVE: begin
        busy_d = 1'b1;
        dp_d_d = cur_data_q;
        if (cnt_q == '0) begin
          state_d = SELECT;
          dp_en_d = (cur_sel_q == SEL_P);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SELECT: begin
        // dp_q sampled on the edge ending SELECT reflects the chosen path.
        busy_d      = 1'b1;
        state_d     = RESP;
        dp_d_d      = cur_data_q;
        rsp_valid_d = 1'b1;
        rsp_id_d    = cur_id_q;
        rsp_data_d  = dp_q;
      end
      RESP: begin
        grant_now = any_win;
        if (!any_win) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared grant path for IDLE and RESP; from RESP this skips IDLE entirely.
    if (grant_now) begin
      state_d    = DRIVE;
      cnt_d      = CNT_INIT;
      gnt_d      = win_oh;
      busy_d     = 1'b1;
      last_gnt_d = win_idx;
      cur_id_d   = win_idx;
      cur_sel_d  = req_sel[win_idx] ? SEL_P : SEL_N;
      cur_data_d = req_data[win_idx];
      dp_d_d     = req_data[win_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= PTR_INIT;
      cur_id_q    <= '0;
      cur_sel_q   <= SEL_N;
      cur_data_q  <= 1'b0;
      gnt_q       <= '0;
      dp_d_q      <= 1'b0;
      dp_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      cur_id_q    <= cur_id_d;
      cur_sel_q   <= cur_sel_d;
      cur_data_q  <= cur_data_d;
      gnt_q       <= gnt_d;
      dp_d_q      <= dp_d_d;
      dp_en_q     <= dp_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign dp_d      = dp_d_q;
  assign dp_en     = dp_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

`ifdef DUAL_EDGE_SCHED_PERF_EN
  // Counts with rsp_valid_d so the count steps on the same edge the pulse
  // rises; 16-bit arithmetic wraps naturally.
  logic [15:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q + {15'd0, rsp_valid_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_edge_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_edge_sched
// Purpose  : Scoreboard bench for dual_edge_sched (NREQ=4, SETTLE_CYC=1).
//            A transaction-level model decides grants from the request levels
//            and pushes expected transactions; a negedge monitor pops them and
//            compares grant, datapath drive, busy and response timing.
//            Also drives a behavioural dual-edge datapath.
// Config   : DUAL_EDGE_SCHED_PERF_EN - also checks perf_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_edge_sched;

  localparam int NREQ = 4;
  localparam int S    = 1;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [NREQ-1:0] req      = '0;
  logic [NREQ-1:0] req_sel  = '0;
  logic [NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic            dp_d, dp_en, dp_q, rsp_valid, rsp_data, busy;
  logic [1:0]      rsp_id;
`ifdef DUAL_EDGE_SCHED_PERF_EN
  logic [15:0]     perf_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ec      = 0;      // rising edges seen since time 0 (outside reset)
  int n_rsp   = 0;      // expected responses since last reset

  typedef struct {
    int              k;     // edge at which the request was sampled
    logic [NREQ-1:0] oh;
    logic [1:0]      id;
    logic            sel;
    logic            data;
  } txn_t;

  txn_t exp_q[$];
  txn_t act;
  logic act_v = 1'b0;

  always #5 clk = ~clk;

  dual_edge_sched #(
    .NREQ       (NREQ),
    .SETTLE_CYC (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_sel    (req_sel),
    .req_data   (req_data),
    .gnt        (gnt),
    .dp_d       (dp_d),
    .dp_en      (dp_en),
    .dp_q       (dp_q),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
`ifdef DUAL_EDGE_SCHED_PERF_EN
    ,
    .perf_cnt   (perf_cnt)
`endif
  );

  // Behavioural dual-edge datapath: P captures on rising, N on falling edge.
  logic p_ff = 1'b0;
  logic n_ff = 1'b0;
  always @(posedge clk) p_ff <= dp_d;
  always @(negedge clk) n_ff <= dp_d;
  assign dp_q = dp_en ? p_ff : n_ff;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", nm, ec, a, e);
    end
  endtask

  // Reference model: a free scheduler grants round-robin from the pointer;
  // it is next free S+2 edges after a grant (end of the response cycle).
  // Held data is what both capture paths see, so it is the expected result.
  initial begin : model
    int   ptr, free_at, w;
    txn_t t;
    ptr     = NREQ - 1;
    free_at = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        ptr     = NREQ - 1;
        free_at = 0;
      end else begin
        ec++;
        if (ec >= free_at && req != '0) begin
          w = -1;
          for (int j = 1; j <= NREQ; j++) begin
            if (w < 0 && req[(ptr + j) % NREQ]) w = (ptr + j) % NREQ;
          end
          t.k    = ec;
          t.oh   = NREQ'(1) << w;
          t.id   = 2'(w);
          t.sel  = req_sel[w];
          t.data = req_data[w];
          exp_q.push_back(t);
          ptr     = w;
          free_at = ec + S + 2;
        end
      end
    end
  end

  // Monitor: checks every output once per cycle on the falling edge.
  initial begin : monitor
    logic [NREQ-1:0] eg;
    int              off;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act_v = 1'b0;
        n_rsp = 0;
        chk("reset_outputs",
            32'({gnt, dp_d, dp_en, rsp_valid, rsp_id, rsp_data, busy}), 0);
      end else begin
        eg = '0;
        if (exp_q.size() > 0 && exp_q[0].k == ec) begin
          act   = exp_q.pop_front();
          act_v = 1'b1;
          eg    = act.oh;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_rsp_same_cycle", 32'((|gnt) && rsp_valid), 0);
        if (act_v) begin
          off = ec - act.k;
          chk("busy", 32'(busy), 1);
          if (off <= S) begin
            chk("dp_d", 32'(dp_d), 32'(act.data));
            chk("dp_en", 32'(dp_en), (off == S) ? 32'(act.sel) : 32'd0);
          end
          if (off == S + 1) begin
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(act.id));
            chk("rsp_data", 32'(rsp_data), 32'(act.data));
            act_v = 1'b0;
            n_rsp++;
          end else begin
            chk("rsp_valid_quiet", 32'(rsp_valid), 0);
          end
        end else begin
          chk("idle_outputs", 32'({dp_d, dp_en, rsp_valid, busy}), 0);
        end
      end
    end
  end

  task automatic new_req(input int i);
    req[i]      = 1'b1;
    req_sel[i]  = 1'($urandom);
    req_data[i] = 1'($urandom);
  endtask

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 20);
    chk("gnt_wait", 32'(gnt[i]), 1);
  endtask

  task automatic idle_wait(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int gi[$];
    int gc[$];
    int cyc;

    // Reset held for a few cycles; monitor checks reset values.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting continuously: expect 0,1,2,3,0 every S+2 cycles.
    for (int i = 0; i < NREQ; i++) new_req(i);
    cyc = 0;
    while (gi.size() < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          gi.push_back(i);
          gc.push_back(cyc);
          new_req(i);
        end
      end
    end
    req = '0;
    chk("rr_count", gi.size(), 5);
    for (int j = 0; j < gi.size(); j++) begin
      chk("rr_order", gi[j], j % NREQ);
      if (j > 0) chk("rr_spacing", gc[j] - gc[j-1], S + 2);
    end

    // Single request on requester 0, P path, data 1.
    idle_wait(6);
    req[0] = 1'b1; req_sel[0] = 1'b1; req_data[0] = 1'b1;
    wait_gnt(0);
    chk("single_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    idle_wait(6);

    // 0101 after requester 0 was served: 2 first, then 0.
    gi.delete();
    new_req(0);
    new_req(2);
    cyc = 0;
    while (gi.size() < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          gi.push_back(i);
          req[i] = 1'b0;
        end
      end
    end
    chk("rr_0101_count", gi.size(), 2);
    if (gi.size() == 2) begin
      chk("rr_0101_first", gi[0], 2);
      chk("rr_0101_second", gi[1], 0);
    end
    idle_wait(6);

    // N path on requester 1 with toggling data.
    for (int t = 0; t < 8; t++) begin
      req[1] = 1'b1; req_sel[1] = 1'b0; req_data[1] = 1'(t & 1);
      wait_gnt(1);
      req[1] = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Randomised traffic: new requests, renewals after grant, early drops.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    idle_wait(8);
`ifdef DUAL_EDGE_SCHED_PERF_EN
    chk("perf_cnt", 32'(perf_cnt), 32'(n_rsp[15:0]));
`endif

    // Reset during SELECT: the in-flight result must vanish, pointer restarts.
    req[1] = 1'b1; req_sel[1] = 1'b1; req_data[1] = 1'b1;
    wait_gnt(1);
    req = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    wait_gnt(0);
    chk("post_reset_gnt", 32'(gnt), 32'(4'b0001));
    idle_wait(10);

    chk("scoreboard_drained", exp_q.size() + int'(act_v), 0);
`ifdef DUAL_EDGE_SCHED_PERF_EN
    chk("perf_cnt_after_reset", 32'(perf_cnt), 32'(n_rsp[15:0]));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
